// File: rtl/ram_dma_copy.sv
// Block-copy engine for a single ram_dp-style RAM port: copies cfg_len words
// from cfg_src to cfg_dst, choosing the direction so overlapping regions behave like memmove.
module ram_dma_copy #(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              cfg_start,
    input  logic [ADDR_MSB:0] cfg_src,
    input  logic [ADDR_MSB:0] cfg_dst,
    input  logic [ADDR_MSB+1:0] cfg_len,
    input  logic              cfg_abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_MSB:0] ram_addr,
    output logic              ram_cen,
    output logic [1:0]        ram_wen,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    localparam int AW = ADDR_MSB + 1;
    localparam int LW = ADDR_MSB + 2;
    localparam logic [LW:0] DEPTH = (LW + 1)'(MEM_SIZE / 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   src_q, dst_q, idx;
    logic [LW-1:0]   rem;
    logic            desc, err_flag;
    logic            range_bad, len_zero;

    // One extra bit of headroom keeps the end-address sums from wrapping
    // even if an out-of-range length is presented.
    assign range_bad = (({2'b00, cfg_src} + {1'b0, cfg_len}) > DEPTH) ||
                       (({2'b00, cfg_dst} + {1'b0, cfg_len}) > DEPTH);
    assign len_zero  = (cfg_len == '0);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cfg_start) state_nxt = (range_bad || len_zero) ? DONE : READ;
            READ:  state_nxt = cfg_abort ? DONE : WRITE;
            WRITE: state_nxt = (cfg_abort || rem == LW'(1)) ? DONE : READ;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            idx      <= '0;
            rem      <= '0;
            desc     <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            if (state == IDLE && cfg_start) begin
                src_q    <= cfg_src;
                dst_q    <= cfg_dst;
                rem      <= cfg_len;
                desc     <= (cfg_dst > cfg_src);
                idx      <= (cfg_dst > cfg_src) ? AW'(cfg_len - LW'(1)) : '0;
                err_flag <= range_bad;
            end else if (state == WRITE) begin
                rem <= rem - LW'(1);
                idx <= desc ? idx - AW'(1) : idx + AW'(1);
            end
        end
    end

    // RAM strobes come from registered state only; write data is the word
    // the RAM returns for the read issued in the preceding cycle.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        ram_cen  = 1'b1;
        ram_wen  = 2'b11;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            READ: begin
                busy     = 1'b1;
                ram_cen  = 1'b0;
                ram_addr = src_q + idx;
            end
            WRITE: begin
                busy     = 1'b1;
                ram_cen  = 1'b0;
                ram_wen  = 2'b00;
                ram_addr = dst_q + idx;
                ram_din  = ram_dout;
            end
            DONE: begin
                done = 1'b1;
                err  = err_flag;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_dma_copy.sv
// Bench for ram_dma_copy: behavioural RAM, memmove access model with a
// per-cycle bus checker, and directed scenarios with literal expectations.
module tb_ram_dma_copy;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic [6:0]  cfg_src = '0;
    logic [6:0]  cfg_dst = '0;
    logic [7:0]  cfg_len = '0;
    logic        cfg_abort = 1'b0;
    logic        busy, done, err;
    logic [6:0]  ram_addr;
    logic        ram_cen;
    logic [1:0]  ram_wen;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    always #5 mclk = ~mclk;

    ram_dma_copy #(.ADDR_MSB(6), .MEM_SIZE(256)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .cfg_start(cfg_start),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
        .cfg_abort(cfg_abort), .busy(busy), .done(done), .err(err),
        .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_wen(ram_wen),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM with registered read data; bench preload goes through ld_* port
    logic [15:0] mem [0:127];
    logic        ld_en = 1'b0;
    logic [6:0]  ld_a = '0;
    logic [15:0] ld_d = '0;

    always @(posedge mclk) begin
        if (ld_en) mem[ld_a] <= ld_d;
        else if (!ram_cen) begin
            if (ram_wen == 2'b11) ram_dout <= mem[ram_addr];
            else begin
                if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
                if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            end
        end
    end

    typedef struct {
        logic [6:0]  addr;
        logic        wr;
        logic [15:0] data;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        cmp_e;
    logic [15:0] mdl [0:127];
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic poke(input int a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_a  = 7'(a);
        ld_d  = d;
        mdl[a] = d;
        @(posedge mclk);
        #1 ld_en = 1'b0;
    endtask

    function automatic bit range_bad(input int src, input int dst, input int len);
        return (src + len > 128) || (dst + len > 128);
    endfunction

    // Expected bus traffic of a memmove; keep>0 truncates to the first keep accesses
    task automatic build_expect(input int src, input int dst, input int len, input int keep);
        int   n;
        int   i;
        acc_t a;
        n = 0;
        if (range_bad(src, dst, len) || len == 0) return;
        for (int k = 0; k < len; k++) begin
            i = (dst > src) ? len - 1 - k : k;
            if (keep == 0 || n < keep) begin
                a.addr = 7'(src + i); a.wr = 1'b0; a.data = '0;
                exp_q.push_back(a);
            end
            n++;
            if (keep == 0 || n < keep) begin
                a.addr = 7'(dst + i); a.wr = 1'b1; a.data = mdl[src + i];
                exp_q.push_back(a);
                mdl[dst + i] = mdl[src + i];
            end
            n++;
        end
    endtask

    task automatic mem_compare(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== mdl[i]) bad++;
        chk(name, bad, 0);
    endtask

    always @(negedge mclk) begin
        if (chk_en && !puc_rst) begin
            chk("busy", int'(busy), int'(exp_q.size() > 0));
            if (!ram_cen) begin
                chk("exp_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cmp_e = exp_q.pop_front();
                    chk("ram_addr", int'(ram_addr), int'(cmp_e.addr));
                    chk("ram_wen", int'(ram_wen), cmp_e.wr ? 0 : 3);
                    if (cmp_e.wr) chk("ram_din", int'(ram_din), int'(cmp_e.data));
                end
            end else begin
                chk("idle_bus", int'({ram_wen, ram_din}), int'({2'b11, 16'h0000}));
            end
        end
    end

    task automatic run(input int src, input int dst, input int len,
                       input int abort_cyc, input int junk_cyc, input bit abort_at_start,
                       output int lat, output bit err_seen);
        int cyc;
        bit got;
        int exp_lat;
        @(negedge mclk);
        cfg_src = 7'(src); cfg_dst = 7'(dst); cfg_len = 8'(len);
        cfg_start = 1'b1; cfg_abort = abort_at_start;
        @(posedge mclk);
        #1 cfg_start = 1'b0; cfg_abort = 1'b0;
        build_expect(src, dst, len, abort_cyc);
        if (range_bad(src, dst, len) || len == 0) exp_lat = 1;
        else if (abort_cyc > 0)                   exp_lat = abort_cyc + 1;
        else                                      exp_lat = 2 * len + 1;
        cyc = 0; got = 1'b0; err_seen = 1'b0;
        while (cyc < 400 && !got) begin
            @(negedge mclk);
            cyc++;
            if (done) begin
                got = 1'b1;
                err_seen = err;
            end else begin
                cfg_abort = (cyc == abort_cyc);
                if (cyc == junk_cyc) begin
                    cfg_start = 1'b1; cfg_src = 7'd7; cfg_dst = 7'd9; cfg_len = 8'd2;
                end else cfg_start = 1'b0;
            end
        end
        cfg_abort = 1'b0; cfg_start = 1'b0;
        lat = got ? cyc : -1;
        chk("latency", lat, exp_lat);
        chk("err", int'(err_seen), int'(range_bad(src, dst, len)));
        @(negedge mclk);
        chk("done_pulse", int'(done), 0);
        chk("exp_drained", exp_q.size(), 0);
        mem_compare("mem_model");
    endtask

    int lat;
    bit e;

    initial begin
        #2 puc_rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cen", int'(ram_cen), 1);
        chk("rst_wen", int'(ram_wen), 3);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_din", int'(ram_din), 0);
        @(negedge mclk); @(negedge mclk);
        puc_rst = 1'b0;
        for (int i = 0; i < 128; i++) poke(i, 16'h5000 + 16'(i));
        chk_en = 1'b1;

        // reset in the second WRITE of a descending len=8 copy
        @(negedge mclk);
        cfg_src = 7'd0; cfg_dst = 7'd50; cfg_len = 8'd8; cfg_start = 1'b1;
        @(posedge mclk);
        #1 cfg_start = 1'b0;
        build_expect(0, 50, 8, 3);
        repeat (3) @(negedge mclk);
        @(posedge mclk);
        #1 chk_en = 1'b0;
        #2 puc_rst = 1'b1;
        #1;
        chk("arst_cen", int'(ram_cen), 1);
        chk("arst_wen", int'(ram_wen), 3);
        chk("arst_busy", int'(busy), 0);
        chk("arst_din", int'(ram_din), 0);
        @(posedge mclk);
        @(negedge mclk);
        puc_rst = 1'b0;
        chk_en = 1'b1;
        chk("arst_q", exp_q.size(), 0);
        chk("arst_w57", int'(mem[57]), 16'h5007);
        chk("arst_w56", int'(mem[56]), 16'h5038);
        mem_compare("arst_mem");

        // basic copy
        poke(0, 16'h1111); poke(1, 16'h2222); poke(2, 16'h3333); poke(3, 16'h4444);
        run(0, 10, 4, 0, 0, 1'b0, lat, e);
        chk("t2_lat", lat, 9);
        chk("t2_m10", int'(mem[10]), 16'h1111);
        chk("t2_m11", int'(mem[11]), 16'h2222);
        chk("t2_m12", int'(mem[12]), 16'h3333);
        chk("t2_m13", int'(mem[13]), 16'h4444);

        // overlapping copies in both directions
        poke(0, 16'h000A); poke(1, 16'h000B); poke(2, 16'h000C); poke(3, 16'h000D); poke(4, 16'hEEEE);
        run(0, 1, 4, 0, 0, 1'b0, lat, e);
        chk("t3_m1", int'(mem[1]), 16'h000A);
        chk("t3_m2", int'(mem[2]), 16'h000B);
        chk("t3_m3", int'(mem[3]), 16'h000C);
        chk("t3_m4", int'(mem[4]), 16'h000D);
        run(1, 0, 4, 0, 0, 1'b0, lat, e);
        chk("t3_m0", int'(mem[0]), 16'h000A);
        chk("t3_m3b", int'(mem[3]), 16'h000D);
        chk("t3_m4b", int'(mem[4]), 16'h000D);

        // zero length and range errors
        run(5, 6, 0, 0, 0, 1'b0, lat, e);
        chk("t4_zero_lat", lat, 1);
        chk("t4_zero_err", int'(e), 0);
        run(126, 0, 3, 0, 0, 1'b0, lat, e);
        chk("t4_src_err", int'(e), 1);
        run(0, 126, 3, 0, 0, 1'b0, lat, e);
        chk("t4_dst_err", int'(e), 1);
        run(0, 0, 128, 0, 0, 1'b0, lat, e);
        chk("t4_full_lat", lat, 257);

        // abort in 2nd READ with an ignored start while busy
        run(40, 20, 5, 3, 2, 1'b0, lat, e);
        chk("t5_lat", lat, 4);
        chk("t5_err", int'(e), 0);
        chk("t5_m20", int'(mem[20]), 16'h5028);
        chk("t5_m21", int'(mem[21]), 16'h5015);

        // start and abort together in IDLE: start is taken
        run(60, 70, 2, 0, 0, 1'b1, lat, e);
        chk("t6_lat", lat, 5);
        chk("t6_m70", int'(mem[70]), 16'h503C);
        chk("t6_m71", int'(mem[71]), 16'h503D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
